alu_result_fifo: RTL and testbench

//  Downstream stage of the 32-bit ALU: captures result Y and flags (Cout, Negative, Zero, Overflow)

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_result_ram.sv | 25 ++
 rtl/alu_result_fifo.sv | 112 +++++++++++
 tb/tb_alu_result_fifo.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: flag bit positions, flag vector and FIFO entry.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned FLAG_W    = 4;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 3;

  typedef logic [FLAG_W-1:0] alu_flags_t;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] y;
    alu_flags_t           f;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_ram.sv
// Entry storage for the ALU result FIFO: one synchronous write port, one
// asynchronous read port, no reset (contents only visible through valid entries).
module alu_result_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 36
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Fall-through read of the addressed entry
  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// ALU result FIFO: buffers Y and {V,Z,N,C} flags between the ALU and the
// writeback consumer with first-word fall-through on the output side.
// Optional sticky status accumulation enabled by ALU_RESULT_FIFO_STICKY_EN.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_y,
  input  logic                     in_cout,
  input  logic                     in_neg,
  input  logic                     in_zero,
  input  logic                     in_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_y,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_sticky,
  output logic [3:0]               sticky_flags
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = $bits(alu_entry_t);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  alu_flags_t       in_flags;
  alu_entry_t       wr_entry;
  alu_entry_t       rd_entry;
  logic [ENT_W-1:0] rd_raw;

  // Handshake decode straight from the held-entry count
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != CNT_W'(0));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Flags are stored exactly as the ALU reported them
  always_comb begin
    in_flags         = '0;
    in_flags[FLAG_C] = in_cout;
    in_flags[FLAG_N] = in_neg;
    in_flags[FLAG_Z] = in_zero;
    in_flags[FLAG_V] = in_ovf;
    wr_entry.y       = ALU_WIDTH'(in_y);
    wr_entry.f       = in_flags;
  end

  // Pointer and occupancy tracking; power-of-two depth wraps pointers naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  alu_result_ram #(
    .DEPTH (DEPTH),
    .DW    (ENT_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_raw)
  );

  // Head entry, masked to zero while the FIFO is empty
  always_comb begin
    rd_entry  = alu_entry_t'(rd_raw);
    out_y     = '0;
    out_flags = '0;
    if (out_valid) begin
      out_y     = WIDTH'(rd_entry.y);
      out_flags = rd_entry.f;
    end
  end

`ifdef ALU_RESULT_FIFO_STICKY_EN
  // Sticky status: clear wins over history, but a same-cycle push still lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (clr_sticky) begin
      sticky_flags <= push ? in_flags : 4'b0;
    end else if (push) begin
      sticky_flags <= sticky_flags | in_flags;
    end
  end
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_flags      = 4'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized + directed bench for alu_result_fifo against a queue-based model.
module tb_alu_result_fifo;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y;
  logic        in_cout, in_neg, in_zero, in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [3:0]  out_flags;
  logic [2:0]  count;
  logic        clr_sticky;
  logic [3:0]  sticky_flags;

  int checks = 0;
  int errors = 0;

  logic [35:0] model_q[$];
  logic [3:0]  model_sticky;

  always #5 clk = ~clk;

  alu_result_fifo #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_y         (in_y),
    .in_cout      (in_cout),
    .in_neg       (in_neg),
    .in_zero      (in_zero),
    .in_ovf       (in_ovf),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_y        (out_y),
    .out_flags    (out_flags),
    .count        (count),
    .clr_sticky   (clr_sticky),
    .sticky_flags (sticky_flags)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every observable output with the model's view of the queue
  task automatic check_outputs(input string tag);
    logic [35:0] head;
    head = (model_q.size() > 0) ? model_q[0] : 36'h0;
    check({tag, ".count"},     64'(count),        64'(model_q.size()));
    check({tag, ".out_valid"}, 64'(out_valid),    64'(model_q.size() > 0));
    check({tag, ".in_ready"},  64'(in_ready),     64'(model_q.size() < DEPTH));
    check({tag, ".out_y"},     64'(out_y),        64'(head[35:4]));
    check({tag, ".out_flags"}, 64'(out_flags),    64'(head[3:0]));
    check({tag, ".sticky"},    64'(sticky_flags), 64'(model_sticky));
  endtask

  // One clock: present inputs, check current state, advance DUT and model
  task automatic cycle(input string tag, input logic iv, input logic [31:0] y,
                       input logic [3:0] f, input logic ordy, input logic clr);
    logic push, pop;
    in_valid   = iv;
    in_y       = y;
    {in_ovf, in_zero, in_neg, in_cout} = f;
    out_ready  = ordy;
    clr_sticky = clr;
    check_outputs(tag);
    push = iv && (model_q.size() < DEPTH);
    pop  = ordy && (model_q.size() > 0);
    @(posedge clk);
    if (pop) void'(model_q.pop_front());
    if (push) model_q.push_back({y, f});
`ifdef ALU_RESULT_FIFO_STICKY_EN
    if (clr) model_sticky = push ? f : 4'b0;
    else if (push) model_sticky = model_sticky | f;
`else
    model_sticky = 4'b0;
`endif
    #1;
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_q.delete();
    model_sticky = 4'b0;
    #3 check_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    in_valid = 0; in_y = 0; {in_ovf, in_zero, in_neg, in_cout} = 4'h0;
    out_ready = 0; clr_sticky = 0;
    model_sticky = 4'b0;
    rst = 1'b1;
    #2;
    do_reset();

    // Fill with flags cycling, then a dropped 5th push, then drain in order
    for (int i = 1; i <= 4; i++) cycle("fill", 1'b1, 32'(i), 4'(i * 3), 1'b0, 1'b0);
    cycle("fill_drop", 1'b1, 32'h5, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("drain", 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Empty: popping does nothing
    for (int i = 0; i < 5; i++) cycle("empty", 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Concurrent push/pop at count=2 across pointer wrap
    cycle("conc_pre", 1'b1, 32'hA, 4'h1, 1'b0, 1'b0);
    cycle("conc_pre", 1'b1, 32'hB, 4'h2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle("conc", 1'b1, 32'hDEAD_BEEF, 4'(i), 1'b1, 1'b0);
    idle("conc_post");

    // Full + pop: push refused this cycle, accepted next
    cycle("fp_fill", 1'b1, 32'h11, 4'h0, 1'b0, 1'b0);
    cycle("fp_fill", 1'b1, 32'h22, 4'h0, 1'b0, 1'b0);
    cycle("fp_full", 1'b1, 32'h77, 4'h5, 1'b1, 1'b0);
    cycle("fp_next", 1'b1, 32'h77, 4'h5, 1'b0, 1'b0);
    idle("fp_post");
    for (int i = 0; i < 4; i++) cycle("fp_drain", 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Sticky sequence (expects zero when feature is compiled out)
    cycle("sticky", 1'b1, 32'h1, 4'b0001, 1'b1, 1'b0);
    cycle("sticky", 1'b1, 32'h2, 4'b1000, 1'b1, 1'b0);
    cycle("sticky_clr", 1'b1, 32'h3, 4'b0100, 1'b1, 1'b1);
    cycle("sticky_clr0", 1'b0, 32'h0, 4'h0, 1'b1, 1'b1);
    idle("sticky_post");

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));

    // Mid-cycle reset with three entries held
    for (int i = 0; i < DEPTH; i++) cycle("pre_rst_drain", 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 32'h100 + 32'(i), 4'hA, 1'b0, 1'b0);
    in_valid = 0; out_ready = 0; clr_sticky = 0;
    #2;
    do_reset();
    idle("post_rst");
    cycle("post_rst_push", 1'b1, 32'h55, 4'h3, 1'b0, 1'b0);
    idle("post_rst_head");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
